// File: rtl/rock_pkg.sv
// Shared types for the rocking search controller: FSM state codes, search axis and
// direction, and the score-width helper.
package rock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_EVAL   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RAMP   = 3'd4
    } state_t;

    typedef enum logic {
        AXIS_AMP  = 1'b0,
        AXIS_FREQ = 1'b1
    } axis_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // One extra bit so cry + heart-rate can never overflow.
    function automatic int score_width(input int cry_w, input int hr_w);
        return ((cry_w > hr_w) ? cry_w : hr_w) + 1;
    endfunction

    function automatic dir_t flip_dir(input dir_t d);
        return (d == DIR_UP) ? DIR_DOWN : DIR_UP;
    endfunction

    function automatic axis_t toggle_axis(input axis_t a);
        return (a == AXIS_AMP) ? AXIS_FREQ : AXIS_AMP;
    endfunction

endpackage

// File: rtl/rock_dwell_timer.sv
// Free-running dwell counter 0..DWELL_CYC-1 with a terminal flag on the last count.
// Shared by the settle dwell and the ramp-down pacing.
module rock_dwell_timer #(
    parameter int DWELL_CYC = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic term_o
);

    localparam int CNT_W = $clog2(DWELL_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Not gated by restart so the controller's next-state logic can use it without a loop.
    assign term_o = (cnt_q == LAST);

endmodule

// File: rtl/rock_search_ctrl.sv
// Hill-climbing rocking controller: holds each amplitude/frequency setting for a dwell,
// scores cry + heart-rate, keeps or steps the setting, then holds and ramps down when calm.
module rock_search_ctrl
    import rock_pkg::*;
#(
    parameter int AMP_W     = 3,
    parameter int FREQ_W    = 3,
    parameter int CRY_W     = 8,
    parameter int HR_W      = 8,
    parameter int DWELL_CYC = 1000,
    parameter int CALM_THR  = 16,
    parameter int QUIET_N   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CRY_W-1:0]  cry_level,
    input  logic              cry_valid,
    input  logic [HR_W-1:0]   hr_level,
    input  logic              hr_valid,
    output logic [AMP_W-1:0]  amp,
    output logic [FREQ_W-1:0] freq,
    output logic              set_upd,
    output logic              calm,
    output logic [2:0]        state_o
);

    localparam int SCORE_W = score_width(CRY_W, HR_W);
    localparam int QW      = $clog2(QUIET_N + 1);

    localparam logic [AMP_W-1:0]  AMP_MAX  = '1;
    localparam logic [FREQ_W-1:0] FREQ_MAX = '1;
    localparam logic [CRY_W-1:0]  CALM_LVL = CRY_W'(CALM_THR);
    localparam logic [QW-1:0]     QUIET_LAST = QW'(QUIET_N - 1);

    state_t               state_q, state_d;
    axis_t                axis_q, axis_d;
    dir_t                 dir_q, dir_d;
    logic [AMP_W-1:0]     amp_q, amp_d;
    logic [FREQ_W-1:0]    freq_q, freq_d;
    logic [SCORE_W-1:0]   best_q, best_d;
    logic [CRY_W-1:0]     cry_lat_q, cry_lat_d;
    logic [HR_W-1:0]      hr_lat_q, hr_lat_d;
    logic                 got_q, got_d;
    logic [QW-1:0]        quiet_q, quiet_d;
    logic                 set_upd_q, set_upd_d;

    logic [SCORE_W-1:0]   score;
    logic                 cry_hi;
    logic                 term;
    logic                 restart;
    logic                 dwell_start;
    axis_t                step_axis;
    dir_t                 step_dir;
    logic                 step_sat;

    // Returns {saturated, new value}; a saturated step leaves the value untouched.
    function automatic logic [AMP_W:0] step_amp(input logic [AMP_W-1:0] v, input dir_t d);
        if (d == DIR_UP) begin
            if (v == AMP_MAX) return {1'b1, v};
            return {1'b0, v + AMP_W'(1)};
        end
        if (v <= AMP_W'(1)) return {1'b1, v};
        return {1'b0, v - AMP_W'(1)};
    endfunction

    function automatic logic [FREQ_W:0] step_freq(input logic [FREQ_W-1:0] v, input dir_t d);
        if (d == DIR_UP) begin
            if (v == FREQ_MAX) return {1'b1, v};
            return {1'b0, v + FREQ_W'(1)};
        end
        if (v <= FREQ_W'(1)) return {1'b1, v};
        return {1'b0, v - FREQ_W'(1)};
    endfunction

    assign score  = SCORE_W'(cry_lat_q) + SCORE_W'(hr_lat_q);
    assign cry_hi = cry_valid && (cry_level > CALM_LVL);

    rock_dwell_timer #(
        .DWELL_CYC (DWELL_CYC)
    ) u_dwell (
        .clk_i     (clk),
        .rst_ni    (reset),
        .restart_i (restart),
        .term_o    (term)
    );

    always_comb begin
        state_d   = state_q;
        axis_d    = axis_q;
        dir_d     = dir_q;
        amp_d     = amp_q;
        freq_d    = freq_q;
        best_d    = best_q;
        quiet_d   = quiet_q;
        step_axis = axis_q;
        step_dir  = dir_q;
        step_sat  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                amp_d  = '0;
                freq_d = '0;
                if (enable && cry_hi) begin
                    amp_d   = AMP_W'(1);
                    freq_d  = FREQ_W'(1);
                    axis_d  = AXIS_AMP;
                    dir_d   = DIR_UP;
                    best_d  = '1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!enable) begin
                    state_d = ST_RAMP;
                end else if (term) begin
                    // Without a fresh sample the dwell simply repeats.
                    state_d = got_q ? ST_EVAL : ST_SETTLE;
                end
            end
            ST_EVAL: begin
                if (!enable) begin
                    state_d = ST_RAMP;
                end else if (cry_lat_q <= CALM_LVL) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_SETTLE;
                    if (score < best_q) begin
                        best_d = score;
                    end else begin
                        step_axis = toggle_axis(axis_q);
                        step_dir  = flip_dir(dir_q);
                    end
                    axis_d = step_axis;
                    dir_d  = step_dir;
                    if (step_axis == AXIS_AMP) begin
                        {step_sat, amp_d} = step_amp(amp_q, step_dir);
                    end else begin
                        {step_sat, freq_d} = step_freq(freq_q, step_dir);
                    end
                    if (step_sat) begin
                        dir_d = flip_dir(step_dir);
                    end
                end
            end
            ST_HOLD: begin
                if (!enable) begin
                    state_d = ST_RAMP;
                end else if (cry_hi) begin
                    best_d  = '1;
                    state_d = ST_SETTLE;
                end else if (cry_valid) begin
                    if (quiet_q == QUIET_LAST) begin
                        state_d = ST_RAMP;
                    end else begin
                        quiet_d = quiet_q + QW'(1);
                    end
                end
            end
            ST_RAMP: begin
                if (cry_hi) begin
                    amp_d   = (amp_q == '0) ? AMP_W'(1) : amp_q;
                    freq_d  = (freq_q == '0) ? FREQ_W'(1) : freq_q;
                    best_d  = '1;
                    state_d = ST_SETTLE;
                end else if ((amp_q == '0) && (freq_q == '0)) begin
                    state_d = ST_IDLE;
                end else if (term) begin
                    amp_d  = (amp_q == '0) ? '0 : amp_q - AMP_W'(1);
                    freq_d = (freq_q == '0) ? '0 : freq_q - FREQ_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != ST_HOLD) begin
            quiet_d = '0;
        end
    end

    // Timer runs only while settling or ramping and restarts on every state change.
    assign restart = (state_d != state_q) ||
                     !((state_q == ST_SETTLE) || (state_q == ST_RAMP));
    assign dwell_start = (state_d == ST_SETTLE) && ((state_q != ST_SETTLE) || term);

    always_comb begin
        cry_lat_d = cry_valid ? cry_level : cry_lat_q;
        hr_lat_d  = hr_valid ? hr_level : hr_lat_q;
        // A strobe on the dwell-start cycle counts toward the new dwell.
        got_d     = (got_q && !dwell_start) || cry_valid || hr_valid;
        set_upd_d = (amp_d != amp_q) || (freq_d != freq_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            axis_q    <= AXIS_AMP;
            dir_q     <= DIR_UP;
            amp_q     <= '0;
            freq_q    <= '0;
            best_q    <= '1;
            cry_lat_q <= '0;
            hr_lat_q  <= '0;
            got_q     <= 1'b0;
            quiet_q   <= '0;
            set_upd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            axis_q    <= axis_d;
            dir_q     <= dir_d;
            amp_q     <= amp_d;
            freq_q    <= freq_d;
            best_q    <= best_d;
            cry_lat_q <= cry_lat_d;
            hr_lat_q  <= hr_lat_d;
            got_q     <= got_d;
            quiet_q   <= quiet_d;
            set_upd_q <= set_upd_d;
        end
    end

    assign amp     = amp_q;
    assign freq    = freq_q;
    assign set_upd = set_upd_q;
    assign calm    = (state_q == ST_HOLD);
    assign state_o = state_q;

endmodule

// File: tb/tb_rock_search_ctrl.sv
// Directed bench for rock_search_ctrl with a short dwell so full search, hold and
// ramp-down sequences fit in a few hundred cycles.
module tb_rock_search_ctrl;

    localparam int DWELL = 8;
    localparam logic [2:0] S_IDLE = 3'd0, S_SETTLE = 3'd1, S_EVAL = 3'd2,
                           S_HOLD = 3'd3, S_RAMP = 3'd4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] cry_level;
    logic       cry_valid;
    logic [7:0] hr_level;
    logic       hr_valid;
    logic [2:0] amp;
    logic [2:0] freq;
    logic       set_upd;
    logic       calm;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    rock_search_ctrl #(
        .AMP_W     (3),
        .FREQ_W    (3),
        .CRY_W     (8),
        .HR_W      (8),
        .DWELL_CYC (DWELL),
        .CALM_THR  (16),
        .QUIET_N   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cry_level (cry_level),
        .cry_valid (cry_valid),
        .hr_level  (hr_level),
        .hr_valid  (hr_valid),
        .amp       (amp),
        .freq      (freq),
        .set_upd   (set_upd),
        .calm      (calm),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
        for (int i = 0; i < budget && state_o !== target; i++) @(negedge clk);
        chk(tag, {13'd0, state_o}, {13'd0, target});
    endtask

    task automatic strobe(input logic [7:0] c, input logic [7:0] h, input logic use_hr);
        cry_level = c;
        cry_valid = 1'b1;
        hr_level  = h;
        hr_valid  = use_hr;
        @(negedge clk);
        cry_valid = 1'b0;
        hr_valid  = 1'b0;
    endtask

    // Feed one sample pair into the current dwell and stop on the cycle the result shows.
    task automatic dwell(input logic [7:0] c, input logic [7:0] h);
        strobe(c, h, 1'b1);
        wait_state(S_EVAL, 4 * DWELL, "reach_eval");
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen_eval;
        logic seen_upd;

        reset = 1'b0; enable = 1'b1;
        cry_level = '0; cry_valid = 1'b0; hr_level = '0; hr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_amp", amp, 0);
        chk("rst_freq", freq, 0);
        chk("rst_upd", set_upd, 0);
        chk("rst_calm", calm, 0);
        chk("rst_state", state_o, S_IDLE);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_upd", set_upd, 0);
        chk("rel_state", state_o, S_IDLE);

        // Loud cry starts the search at 1/1
        strobe(8'd200, 8'd100, 1'b1);
        chk("start_amp", amp, 1);
        chk("start_freq", freq, 1);
        chk("start_upd", set_upd, 1);
        chk("start_state", state_o, S_SETTLE);
        @(negedge clk);
        chk("start_upd_off", set_upd, 0);

        // Strictly improving scores walk amp up to its ceiling
        dwell(8'd200, 8'd100);
        chk("imp300_amp", amp, 2);
        chk("imp300_upd", set_upd, 1);
        chk("imp300_state", state_o, S_SETTLE);
        dwell(8'd150, 8'd100);
        chk("imp250_amp", amp, 3);
        dwell(8'd120, 8'd80);
        chk("imp200_amp", amp, 4);
        dwell(8'd100, 8'd50);
        chk("imp150_amp", amp, 5);
        dwell(8'd60, 8'd40);
        chk("imp100_amp", amp, 6);
        dwell(8'd40, 8'd20);
        chk("imp60_amp", amp, 7);
        chk("imp60_freq", freq, 1);
        dwell(8'd30, 8'd10);
        chk("sat_amp", amp, 7);
        chk("sat_upd", set_upd, 0);
        chk("sat_state", state_o, S_SETTLE);

        // Worse score: direction flips back up, axis moves to freq
        dwell(8'd100, 8'd0);
        chk("worse_freq", freq, 2);
        chk("worse_amp", amp, 7);
        chk("worse_upd", set_upd, 1);

        // No sample during the dwell: settle repeats with no update
        seen_eval = 1'b0;
        seen_upd  = 1'b0;
        repeat (2 * DWELL + 4) begin
            @(negedge clk);
            if (state_o === S_EVAL) seen_eval = 1'b1;
            if (set_upd === 1'b1) seen_upd = 1'b1;
        end
        chk("stale_no_eval", seen_eval, 0);
        chk("stale_no_upd", seen_upd, 0);
        chk("stale_state", state_o, S_SETTLE);
        chk("stale_amp", amp, 7);
        chk("stale_freq", freq, 2);

        // Calm cry at evaluation -> HOLD, then quiet samples -> RAMP
        dwell(8'd10, 8'd50);
        chk("hold_state", state_o, S_HOLD);
        chk("hold_calm", calm, 1);
        chk("hold_amp", amp, 7);
        chk("hold_freq", freq, 2);
        repeat (7) strobe(8'd5, 8'd0, 1'b0);
        chk("hold7_state", state_o, S_HOLD);
        strobe(8'd5, 8'd0, 1'b0);
        chk("ramp_state", state_o, S_RAMP);
        chk("ramp_calm", calm, 0);
        for (int i = 0; i < 4 * DWELL && amp === 3'd7; i++) @(negedge clk);
        chk("ramp1_amp", amp, 6);
        chk("ramp1_freq", freq, 1);
        wait_state(S_IDLE, 12 * DWELL, "ramp_idle");
        chk("ramp_end_amp", amp, 0);
        chk("ramp_end_freq", freq, 0);

        // Asynchronous reset in the middle of a settle at amp=5
        strobe(8'd200, 8'd100, 1'b1);
        chk("re_start_amp", amp, 1);
        dwell(8'd200, 8'd100);
        dwell(8'd150, 8'd100);
        dwell(8'd120, 8'd80);
        dwell(8'd100, 8'd50);
        chk("pre_rst_amp", amp, 5);
        chk("pre_rst_state", state_o, S_SETTLE);
        #2 reset = 1'b0;
        #1;
        chk("async_amp", amp, 0);
        chk("async_freq", freq, 0);
        chk("async_state", state_o, S_IDLE);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rel2_upd", set_upd, 0);
        strobe(8'd200, 8'd100, 1'b1);
        chk("restart_amp", amp, 1);
        chk("restart_freq", freq, 1);
        chk("restart_state", state_o, S_SETTLE);

        // enable low forces ramp-down; a loud cry in IDLE is ignored while disabled
        enable = 1'b0;
        @(negedge clk);
        chk("dis_state", state_o, S_RAMP);
        wait_state(S_IDLE, 4 * DWELL, "dis_idle");
        chk("dis_amp", amp, 0);
        strobe(8'd200, 8'd100, 1'b1);
        chk("dis_no_start", state_o, S_IDLE);
        enable = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
